// File: rtl/cipher_pair_reader.sv
// Walks the encrypted-image ROM one byte pair at a time and presents each
// big-endian pair as a 16-bit ciphertext word on a valid/ready handshake.
module cipher_pair_reader #(
   parameter int ADDR_W    = 11,
   parameter int NUM_PAIRS = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_data,
   output logic [15:0]       out_word,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-2:0] pair_idx,
   output logic              busy,
   output logic              done,
   output logic [2:0]        state_o
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_FETCH_HI = 3'd1;
   localparam logic [2:0] S_LATCH_HI = 3'd2;
   localparam logic [2:0] S_LATCH_LO = 3'd3;
   localparam logic [2:0] S_PRESENT  = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;

   localparam logic [ADDR_W-2:0] LAST_IDX = (ADDR_W-1)'(NUM_PAIRS - 1);

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-2:0] idx_q, idx_d;
   logic [7:0]        hi_q, hi_d;
   logic [7:0]        lo_q, lo_d;

   // Handshake: out_valid is high only in PRESENT and stays high, with
   // out_word unchanged, until a rising edge sees out_valid && out_ready.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_FETCH_HI;
               idx_d   = '0;
            end
         end
         S_FETCH_HI: state_d = S_LATCH_HI;
         S_LATCH_HI: begin
            hi_d    = rom_data;
            state_d = S_LATCH_LO;
         end
         S_LATCH_LO: begin
            lo_d    = rom_data;
            state_d = S_PRESENT;
         end
         S_PRESENT: begin
            if (out_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = S_FETCH_HI;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // Odd (low-byte) address is issued only in LATCH_HI, while the high byte returns.
   assign rom_addr  = {idx_q, (state_q == S_LATCH_HI)};
   assign out_word  = {hi_q, lo_q};
   assign out_valid = (state_q == S_PRESENT);
   assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done      = (state_q == S_DONE);
   assign pair_idx  = idx_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_cipher_pair_reader.sv
// Directed bench for cipher_pair_reader: three instances cover NUM_PAIRS=1,
// a four-pair image on the default width, and the ADDR_W=3 boundary.
module tb_cipher_pair_reader;

   logic clk = 1'b0;
   logic rst;
   logic out_ready;
   int   tests_run = 0;
   int   tests_failed = 0;
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   // single-pair instance
   logic        start_s;
   logic [10:0] rom_addr_s;
   logic [7:0]  rom_s_q;
   logic [15:0] word_s;
   logic        valid_s, busy_s, done_s;
   logic [9:0]  idx_s;
   logic [2:0]  state_s;

   // four-pair instance
   logic        start_m;
   logic [10:0] rom_addr_m;
   logic [7:0]  rom_m_q;
   logic [15:0] word_m;
   logic        valid_m, busy_m, done_m;
   logic [9:0]  idx_m;
   logic [2:0]  state_m;

   // narrow-address instance
   logic        start_w;
   logic [2:0]  rom_addr_w;
   logic [7:0]  rom_w_q;
   logic [15:0] word_w;
   logic        valid_w, busy_w, done_w;
   logic [1:0]  idx_w;
   logic [2:0]  state_w;

   cipher_pair_reader #(.ADDR_W(11), .NUM_PAIRS(1)) dut_s (
      .clk(clk), .rst(rst), .start(start_s), .rom_addr(rom_addr_s),
      .rom_data(rom_s_q), .out_word(word_s), .out_valid(valid_s),
      .out_ready(out_ready), .pair_idx(idx_s), .busy(busy_s),
      .done(done_s), .state_o(state_s));

   cipher_pair_reader #(.ADDR_W(11), .NUM_PAIRS(4)) dut_m (
      .clk(clk), .rst(rst), .start(start_m), .rom_addr(rom_addr_m),
      .rom_data(rom_m_q), .out_word(word_m), .out_valid(valid_m),
      .out_ready(out_ready), .pair_idx(idx_m), .busy(busy_m),
      .done(done_m), .state_o(state_m));

   cipher_pair_reader #(.ADDR_W(3), .NUM_PAIRS(4)) dut_w (
      .clk(clk), .rst(rst), .start(start_w), .rom_addr(rom_addr_w),
      .rom_data(rom_w_q), .out_word(word_w), .out_valid(valid_w),
      .out_ready(out_ready), .pair_idx(idx_w), .busy(busy_w),
      .done(done_w), .state_o(state_w));

   // Synchronous ROM models: data for the address seen at an edge appears after it.
   always @(posedge clk) begin
      rom_s_q <= (rom_addr_s == 11'd0) ? 8'h12 : (rom_addr_s == 11'd1) ? 8'h34 : 8'h00;
      rom_m_q <= rom_addr_m[7:0] ^ 8'hA5;
      rom_w_q <= {5'b0, rom_addr_w} ^ 8'hA5;
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      start_s = 1'b0; start_m = 1'b0; start_w = 1'b0;
      out_ready = 1'b1;
      step; step;
      tests_run++;
      if ({word_m, valid_m, busy_m, done_m} !== 19'd0) begin
         tests_failed++;
         $display("FAIL reset_outputs: word/valid/busy/done=%h required 0", {word_m, valid_m, busy_m, done_m});
      end
      tests_run++;
      if ({rom_addr_m, idx_m, state_m} !== 24'd0) begin
         tests_failed++;
         $display("FAIL reset_addr_idx: addr=%0d idx=%0d state=%0d required 0", rom_addr_m, idx_m, state_m);
      end
      tests_run++;
      if ({valid_s, busy_s, done_s, valid_w, busy_w, done_w} !== 6'd0) begin
         tests_failed++;
         $display("FAIL reset_other_duts: flags=%b required 000000", {valid_s, busy_s, done_s, valid_w, busy_w, done_w});
      end
      rst = 1'b0;
      step;
   endtask

   task automatic test_basic_pair;
      out_ready = 1'b1;
      start_s = 1'b1;
      step;                 // E0
      start_s = 1'b0;
      tests_run++;
      if (busy_s !== 1'b1 || rom_addr_s !== 11'd0) begin
         tests_failed++;
         $display("FAIL basic_fetch: busy=%b addr=%0d required busy=1 addr=0", busy_s, rom_addr_s);
      end
      step;                 // E1
      tests_run++;
      if (rom_addr_s !== 11'd1) begin
         tests_failed++;
         $display("FAIL basic_latch_hi_addr: addr=%0d required 1", rom_addr_s);
      end
      step;                 // E2
      tests_run++;
      if (valid_s !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_early_valid: valid=%b required 0", valid_s);
      end
      step;                 // E3
      tests_run++;
      if (valid_s !== 1'b1 || word_s !== 16'h1234) begin
         tests_failed++;
         $display("FAIL basic_word: valid=%b word=%h required valid=1 word=1234", valid_s, word_s);
      end
      step;                 // E4: accepted
      tests_run++;
      if (done_s !== 1'b1 || busy_s !== 1'b0 || valid_s !== 1'b0 || idx_s !== 10'd0) begin
         tests_failed++;
         $display("FAIL basic_done: done=%b busy=%b valid=%b idx=%0d required 1 0 0 0", done_s, busy_s, valid_s, idx_s);
      end
   endtask

   task automatic test_streaming;
      logic [15:0] exp;
      out_ready = 1'b1;
      exp_q = {16'hA5A4, 16'hA7A6, 16'hA1A0, 16'hA3A2};
      start_m = 1'b1;
      step;
      start_m = 1'b0;
      for (int p = 0; p < 4; p++) begin
         exp = exp_q.pop_front();
         tests_run++;
         if (rom_addr_m !== 11'(2 * p) || valid_m !== 1'b0) begin
            tests_failed++;
            $display("FAIL stream_fetch_p%0d: addr=%0d valid=%b required addr=%0d valid=0", p, rom_addr_m, valid_m, 2 * p);
         end
         step;
         tests_run++;
         if (rom_addr_m !== 11'(2 * p + 1)) begin
            tests_failed++;
            $display("FAIL stream_latch_hi_p%0d: addr=%0d required %0d", p, rom_addr_m, 2 * p + 1);
         end
         step;
         tests_run++;
         if (rom_addr_m !== 11'(2 * p) || valid_m !== 1'b0) begin
            tests_failed++;
            $display("FAIL stream_latch_lo_p%0d: addr=%0d valid=%b required addr=%0d valid=0", p, rom_addr_m, valid_m, 2 * p);
         end
         step;
         tests_run++;
         if (valid_m !== 1'b1 || word_m !== exp || idx_m !== 10'(p)) begin
            tests_failed++;
            $display("FAIL stream_word_p%0d: valid=%b word=%h idx=%0d required valid=1 word=%h idx=%0d", p, valid_m, word_m, idx_m, exp, p);
         end
         step;
      end
      tests_run++;
      if (done_m !== 1'b1 || busy_m !== 1'b0 || idx_m !== 10'd3 || valid_m !== 1'b0) begin
         tests_failed++;
         $display("FAIL stream_done: done=%b busy=%b idx=%0d valid=%b required 1 0 3 0", done_m, busy_m, idx_m, valid_m);
      end
   endtask

   task automatic test_backpressure;
      out_ready = 1'b1;
      start_m = 1'b1;
      step;
      start_m = 1'b0;
      repeat (8) step;      // pairs 0 and 1 stream through
      out_ready = 1'b0;
      repeat (3) step;      // PRESENT of pair 2
      for (int c = 0; c < 6; c++) begin
         tests_run++;
         if (valid_m !== 1'b1 || word_m !== 16'hA1A0 || rom_addr_m !== 11'd4 || idx_m !== 10'd2) begin
            tests_failed++;
            $display("FAIL bp_hold_c%0d: valid=%b word=%h addr=%0d idx=%0d required 1 A1A0 4 2", c, valid_m, word_m, rom_addr_m, idx_m);
         end
         if (c < 5) step;
      end
      out_ready = 1'b1;
      step;
      tests_run++;
      if (valid_m !== 1'b0 || idx_m !== 10'd3 || rom_addr_m !== 11'd6) begin
         tests_failed++;
         $display("FAIL bp_accept_once: valid=%b idx=%0d addr=%0d required 0 3 6", valid_m, idx_m, rom_addr_m);
      end
      repeat (4) step;
      tests_run++;
      if (done_m !== 1'b1 || idx_m !== 10'd3) begin
         tests_failed++;
         $display("FAIL bp_done: done=%b idx=%0d required 1 3", done_m, idx_m);
      end
   endtask

   task automatic test_start_while_busy;
      out_ready = 1'b1;
      start_m = 1'b1;
      step;
      start_m = 1'b0;
      repeat (5) step;      // LATCH_HI of pair 1
      tests_run++;
      if (idx_m !== 10'd1 || rom_addr_m !== 11'd3) begin
         tests_failed++;
         $display("FAIL swb_setup: idx=%0d addr=%0d required 1 3", idx_m, rom_addr_m);
      end
      start_m = 1'b1;
      step;
      start_m = 1'b0;
      step;                 // PRESENT of pair 1
      tests_run++;
      if (valid_m !== 1'b1 || word_m !== 16'hA7A6 || idx_m !== 10'd1) begin
         tests_failed++;
         $display("FAIL swb_no_restart: valid=%b word=%h idx=%0d required 1 A7A6 1", valid_m, word_m, idx_m);
      end
      step;
      tests_run++;
      if (idx_m !== 10'd2 || rom_addr_m !== 11'd4) begin
         tests_failed++;
         $display("FAIL swb_continue: idx=%0d addr=%0d required 2 4", idx_m, rom_addr_m);
      end
      repeat (8) step;
      tests_run++;
      if (done_m !== 1'b1) begin
         tests_failed++;
         $display("FAIL swb_done: done=%b required 1", done_m);
      end
      start_m = 1'b1;
      step;
      start_m = 1'b0;
      tests_run++;
      if (busy_m !== 1'b1 || idx_m !== 10'd0 || done_m !== 1'b0) begin
         tests_failed++;
         $display("FAIL swb_restart: busy=%b idx=%0d done=%b required 1 0 0", busy_m, idx_m, done_m);
      end
      repeat (3) step;
      tests_run++;
      if (valid_m !== 1'b1 || word_m !== 16'hA5A4) begin
         tests_failed++;
         $display("FAIL swb_restart_word: valid=%b word=%h required 1 A5A4", valid_m, word_m);
      end
   endtask

   task automatic test_reset_mid;
      out_ready = 1'b1;
      repeat (9) step;      // from PRESENT p0 to FETCH_HI p3
      step; step;           // LATCH_LO p3
      tests_run++;
      if (idx_m !== 10'd3 || busy_m !== 1'b1 || rom_addr_m !== 11'd6) begin
         tests_failed++;
         $display("FAIL rmid_setup: idx=%0d busy=%b addr=%0d required 3 1 6", idx_m, busy_m, rom_addr_m);
      end
      #3 rst = 1'b1;
      #1;
      tests_run++;
      if ({word_m, valid_m, busy_m, done_m, rom_addr_m, idx_m, state_m} !== 43'd0) begin
         tests_failed++;
         $display("FAIL rmid_async: word=%h valid=%b busy=%b done=%b addr=%0d idx=%0d required all 0", word_m, valid_m, busy_m, done_m, rom_addr_m, idx_m);
      end
      #10 rst = 1'b0;
      step;
      start_m = 1'b1;
      step;
      start_m = 1'b0;
      repeat (3) step;
      tests_run++;
      if (valid_m !== 1'b1 || word_m !== 16'hA5A4 || idx_m !== 10'd0) begin
         tests_failed++;
         $display("FAIL rmid_restart_word: valid=%b word=%h idx=%0d required 1 A5A4 0", valid_m, word_m, idx_m);
      end
   endtask

   task automatic test_wrap;
      logic [15:0] exp;
      out_ready = 1'b1;
      exp_q = {16'hA5A4, 16'hA7A6, 16'hA1A0, 16'hA3A2};
      start_w = 1'b1;
      step;
      start_w = 1'b0;
      for (int p = 0; p < 4; p++) begin
         exp = exp_q.pop_front();
         tests_run++;
         if (rom_addr_w !== 3'(2 * p)) begin
            tests_failed++;
            $display("FAIL wrap_fetch_p%0d: addr=%0d required %0d", p, rom_addr_w, 2 * p);
         end
         step;
         tests_run++;
         if (rom_addr_w !== 3'(2 * p + 1)) begin
            tests_failed++;
            $display("FAIL wrap_latch_hi_p%0d: addr=%0d required %0d", p, rom_addr_w, 2 * p + 1);
         end
         step; step;
         tests_run++;
         if (valid_w !== 1'b1 || word_w !== exp || done_w !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_word_p%0d: valid=%b word=%h done=%b required 1 %h 0", p, valid_w, word_w, done_w, exp);
         end
         step;
      end
      tests_run++;
      if (done_w !== 1'b1 || busy_w !== 1'b0 || idx_w !== 2'd3 || rom_addr_w !== 3'd6) begin
         tests_failed++;
         $display("FAIL wrap_done: done=%b busy=%b idx=%0d addr=%0d required 1 0 3 6", done_w, busy_w, idx_w, rom_addr_w);
      end
   endtask

   initial begin
      test_reset;
      test_basic_pair;
      test_streaming;
      test_backpressure;
      test_start_while_busy;
      test_reset_mid;
      test_wrap;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
